// File: rtl/rst_seq.sv
// rst_seq: releases per-domain active-low resets in order once reset is released and PLL lock is stable.
module rst_seq #(
    parameter int STAGES    = 3,
    parameter int LOCK_FILT = 4,
    parameter int HOLD_CYC  = 16,
    parameter int GAP_CYC   = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rst_sync,
    input  logic              pll_locked,
    output logic [STAGES-1:0] stage_rst_n,
    output logic              init_done,
    output logic [2:0]        state_o
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD      = 3'd2,
        RELEASE   = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(STAGES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_idx;
    logic [1:0]        r_sync;
    logic [STAGES-1:0] r_stage;
    logic              r_done;
    logic              w_locked;
    logic              w_abort;

    assign w_locked    = r_sync[1];
    assign w_abort     = !rst_sync || !w_locked;
    assign stage_rst_n = r_stage;
    assign init_done   = r_done;
    assign state_o     = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sync  <= '0;
            r_stage <= '0;
            r_done  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], pll_locked};
            case (r_state)
                IDLE: begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_stage <= '0;
                    r_done  <= 1'b0;
                    if (rst_sync) r_state <= WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (!rst_sync) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (!w_locked) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD, RELEASE, DONE: begin
                    // reset-release loss outranks lock loss
                    if (w_abort) begin
                        r_state <= rst_sync ? WAIT_LOCK : IDLE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_stage <= '0;
                        r_done  <= 1'b0;
                    end else if (r_state == HOLD) begin
                        if (r_cnt == HOLD_LAST) begin
                            r_state <= RELEASE;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_state == RELEASE) begin
                        if (r_cnt == GAP_LAST) begin
                            r_stage <= r_stage | (STAGES'(1) << r_idx);
                            r_cnt   <= '0;
                            r_idx   <= r_idx + 1'b1;
                            if (r_idx == IDX_LAST) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_stage <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
